// File: rtl/count_pwm_pkg.sv
// count_pwm_pkg: shared counter width, terminal count and PWM FSM state encoding.
package count_pwm_pkg;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
  typedef enum logic [1:0] {DISABLED = 2'd0, ARMED = 2'd1, RUNNING = 2'd2} pwm_state_t;
endpackage

// File: rtl/count_wrap_detect.sv
// count_wrap_detect: remembers the previous count and flags 15->0 wraps and any count change.
module count_wrap_detect
  import count_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             changed
);
  logic [CNT_W-1:0] prev_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev_count <= '0;
    else prev_count <= count;
  assign wrap = prev_count == CNT_MAX && count == '0;
  assign changed = count != prev_count;
endmodule

// File: rtl/count_compare_pwm.sv
// count_compare_pwm: double-buffered PWM, wrap/match pulses and saturating period count.
// Optional sticky irq/irq_clr ports when COUNT_COMPARE_PWM_IRQ_EN is defined.
module count_compare_pwm
  import count_pwm_pkg::*;
#(
  parameter int               PERIOD_W = 8,
  parameter logic [CNT_W-1:0] DUTY_RST = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [CNT_W-1:0]    count,
  input  logic                duty_wr,
  input  logic [CNT_W-1:0]    duty_data,
  output logic                duty_pending,
  output logic                pwm_out,
  output logic                wrap_pulse,
  output logic                match_pulse,
  output logic [PERIOD_W-1:0] period_cnt,
  output logic [1:0]          state_o
`ifdef COUNT_COMPARE_PWM_IRQ_EN
  ,
  input  logic                irq_clr,
  output logic                irq
`endif
);
  pwm_state_t state, state_next;
  logic wrap, changed, run_next, wrap_ev, match_ev;
  logic [CNT_W-1:0] duty_active, duty_shadow, duty_next;
  count_wrap_detect u_wrap (
    .clk(clk),
    .reset(reset),
    .count(count),
    .wrap(wrap),
    .changed(changed)
  );
  always_comb begin
    state_next = DISABLED;
    if (en)
      state_next = (state == DISABLED) ? ARMED :
                   (state == ARMED)    ? (wrap ? RUNNING : ARMED) :
                   (state == RUNNING)  ? RUNNING : DISABLED;
  end
  assign duty_next = (wrap && duty_pending) ? duty_shadow : duty_active;
  assign run_next = state_next == RUNNING;
  assign wrap_ev = wrap && (state == RUNNING || run_next);
  // A zero duty has no high phase, so there is no falling edge to flag as a match.
  assign match_ev = state == RUNNING && changed && count == duty_active && duty_active != '0;
  assign state_o = state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= DISABLED;
      duty_active <= DUTY_RST;
      duty_shadow <= DUTY_RST;
      duty_pending <= 1'b0;
      pwm_out <= 1'b0;
      wrap_pulse <= 1'b0;
      match_pulse <= 1'b0;
      period_cnt <= '0;
    end else begin
      state <= state_next;
      duty_active <= duty_next;
      duty_shadow <= duty_wr ? duty_data : duty_shadow;
      duty_pending <= duty_wr || (duty_pending && !wrap);
      pwm_out <= run_next && count < duty_next;
      wrap_pulse <= wrap_ev;
      match_pulse <= match_ev;
      period_cnt <= (state != ARMED && state_next == ARMED) ? '0 :
                    (wrap_ev && period_cnt != '1) ? period_cnt + 1'b1 : period_cnt;
    end
`ifdef COUNT_COMPARE_PWM_IRQ_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) irq <= 1'b0;
    else irq <= wrap_ev || match_ev || (irq && !irq_clr);
`endif
endmodule

// File: tb/tb_count_compare_pwm.sv
// tb_count_compare_pwm: table plus hand sequences, expectations queued per step and checked a cycle later.
module tb_count_compare_pwm;
  import count_pwm_pkg::*;
  typedef struct packed {
    logic pwm, wrp, mat, pend;
    logic [1:0] st;
    logic [7:0] per;
  } exp_t;
  typedef struct {
    logic en;
    logic [3:0] c;
    logic wr;
    logic [3:0] d;
    exp_t x;
  } vec_t;
  logic clk, reset, en, duty_wr;
  logic [3:0] count, duty_data;
  logic duty_pending, pwm_out, wrap_pulse, match_pulse;
  logic [7:0] period_cnt;
  logic [1:0] state_o;
  logic pend2, pwm2, wrp2, mat2;
  logic [1:0] per2, st2;
  int passed = 0, total = 0;
  exp_t sb[$];
  vec_t tbl[6];
`ifdef COUNT_COMPARE_PWM_IRQ_EN
  logic irq, irq2;
  logic irq_clr = 1'b0;
`endif
  count_compare_pwm dut (
    .clk(clk), .reset(reset), .en(en), .count(count), .duty_wr(duty_wr), .duty_data(duty_data),
    .duty_pending(duty_pending), .pwm_out(pwm_out), .wrap_pulse(wrap_pulse),
    .match_pulse(match_pulse), .period_cnt(period_cnt), .state_o(state_o)
`ifdef COUNT_COMPARE_PWM_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );
  count_compare_pwm #(.PERIOD_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .count(count), .duty_wr(duty_wr), .duty_data(duty_data),
    .duty_pending(pend2), .pwm_out(pwm2), .wrap_pulse(wrp2),
    .match_pulse(mat2), .period_cnt(per2), .state_o(st2)
`ifdef COUNT_COMPARE_PWM_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq2)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t ex(logic [3:0] f, logic [1:0] st, logic [7:0] per);
    ex = {f, st, per};
  endfunction
  task automatic check(input string nm);
    exp_t e, a;
    logic [1:0] e2;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    a = {pwm_out, wrap_pulse, match_pulse, duty_pending, state_o, period_cnt};
    if (a === e) passed++;
    else $display("FAIL %s: got pwm=%b wrap=%b match=%b pend=%b st=%0d per=%0d, expected pwm=%b wrap=%b match=%b pend=%b st=%0d per=%0d",
                  nm, a.pwm, a.wrp, a.mat, a.pend, a.st, a.per, e.pwm, e.wrp, e.mat, e.pend, e.st, e.per);
    e2 = (e.per > 8'd3) ? 2'd3 : e.per[1:0];
    total++;
    if (per2 === e2) passed++;
    else $display("FAIL %s_sat2: got period_cnt=%0d expected %0d", nm, per2, e2);
  endtask
  task automatic step(input logic e, input logic [3:0] c, input logic w, input logic [3:0] d,
                      input exp_t x, input string nm);
    en = e;
    count = c;
    duty_wr = w;
    duty_data = d;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check($sformatf("%s@c%0d", nm, c));
  endtask
  task automatic run(input int c0, input int c1, input logic [3:0] d, input logic p, input logic [7:0] per);
    for (int c = c0; c <= c1; c++) begin
      logic [3:0] cv;
      cv = 4'(c);
      step(1'b1, cv, 1'b0, 4'd0, ex({cv < d, 1'b0, cv == d && d != 4'd0, p}, RUNNING, per), "run");
    end
  endtask
  task automatic check_zero(input string nm);
    total++;
    if ({pwm_out, wrap_pulse, match_pulse, duty_pending, period_cnt} === '0 && state_o === DISABLED) passed++;
    else $display("FAIL %s: got pwm=%b wrap=%b match=%b pend=%b per=%0d st=%0d, required all 0",
                  nm, pwm_out, wrap_pulse, match_pulse, duty_pending, period_cnt, state_o);
  endtask
  initial begin
    tbl[0] = '{1'b0, 4'd0,  1'b1, 4'd5, ex(4'b0001, DISABLED, 8'd0)};
    tbl[1] = '{1'b1, 4'd7,  1'b0, 4'd0, ex(4'b0001, ARMED,    8'd0)};
    tbl[2] = '{1'b1, 4'd10, 1'b0, 4'd0, ex(4'b0001, ARMED,    8'd0)};
    tbl[3] = '{1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0001, ARMED,    8'd0)};
    tbl[4] = '{1'b1, 4'd0,  1'b0, 4'd0, ex(4'b1100, RUNNING,  8'd1)};
    tbl[5] = '{1'b1, 4'd1,  1'b0, 4'd0, ex(4'b1000, RUNNING,  8'd1)};
    reset = 1'b1; en = 1'b0; count = 4'd0; duty_wr = 1'b0; duty_data = 4'd0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_state");
    reset = 1'b0;
    // arming from DISABLED with duty 5 written beforehand
    for (int i = 0; i < 6; i++) step(tbl[i].en, tbl[i].c, tbl[i].wr, tbl[i].d, tbl[i].x, $sformatf("t2_tbl%0d", i));
    run(2, 15, 4'd5, 1'b0, 8'd1);
    // double buffer: write 12 mid-period
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1100, RUNNING, 8'd2), "t3_wrap");
    run(1, 2, 4'd5, 1'b0, 8'd2);
    step(1'b1, 4'd3, 1'b1, 4'd12, ex(4'b1001, RUNNING, 8'd2), "t3_wr");
    run(4, 15, 4'd5, 1'b1, 8'd2);
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1100, RUNNING, 8'd3), "t3_apply");
    run(1, 13, 4'd12, 1'b0, 8'd3);
    // write on the wrap cycle while a different value is pending
    step(1'b1, 4'd14, 1'b1, 4'd2, ex(4'b0001, RUNNING, 8'd3), "t4_wr2");
    step(1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0001, RUNNING, 8'd3), "t4_hold");
    step(1'b1, 4'd0, 1'b1, 4'd9, ex(4'b1101, RUNNING, 8'd4), "t4_wrap");
    run(1, 15, 4'd2, 1'b1, 8'd4);
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1100, RUNNING, 8'd5), "t4_next");
    run(1, 9, 4'd9, 1'b0, 8'd5);
    // duty 0 then duty 15
    step(1'b1, 4'd10, 1'b1, 4'd0, ex(4'b0001, RUNNING, 8'd5), "t5_wr0");
    run(11, 15, 4'd9, 1'b1, 8'd5);
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b0100, RUNNING, 8'd6), "t5_d0_wrap");
    run(1, 15, 4'd0, 1'b0, 8'd6);
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b0100, RUNNING, 8'd7), "t5_d0_again");
    run(1, 14, 4'd0, 1'b0, 8'd7);
    step(1'b1, 4'd15, 1'b1, 4'd15, ex(4'b0001, RUNNING, 8'd7), "t5_wr15");
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1100, RUNNING, 8'd8), "t5_d15_wrap");
    run(1, 15, 4'd15, 1'b0, 8'd8);
    // stall on the duty value, then a load of 0 from 9
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1100, RUNNING, 8'd9), "t6_wrap");
    run(1, 14, 4'd15, 1'b0, 8'd9);
    step(1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0010, RUNNING, 8'd9), "t6_hit");
    for (int i = 0; i < 3; i++) step(1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0000, RUNNING, 8'd9), "t6_stall");
    step(1'b1, 4'd9, 1'b0, 4'd0, ex(4'b1000, RUNNING, 8'd9), "t6_pre_load");
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1000, RUNNING, 8'd9), "t6_load");
    // en=0 on a wrap while ARMED
    step(1'b0, 4'd1, 1'b0, 4'd0, ex(4'b0000, DISABLED, 8'd9), "t6_dis");
    step(1'b1, 4'd14, 1'b0, 4'd0, ex(4'b0000, ARMED, 8'd0), "t6_arm");
    step(1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0000, ARMED, 8'd0), "t6_arm15");
    step(1'b0, 4'd0, 1'b0, 4'd0, ex(4'b0000, DISABLED, 8'd0), "t6_en0_wrap");
    // asynchronous reset while pwm_out is high
    step(1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0000, ARMED, 8'd0), "t1_arm");
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b1100, RUNNING, 8'd1), "t1_wrap_pre");
    step(1'b1, 4'd1, 1'b0, 4'd0, ex(4'b1000, RUNNING, 8'd1), "t1_high");
    #2 reset = 1'b1;
    #1 check_zero("t1_async_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 4'd3, 1'b0, 4'd0, ex(4'b0000, ARMED, 8'd0), "t1_rearm");
    step(1'b1, 4'd15, 1'b0, 4'd0, ex(4'b0000, ARMED, 8'd0), "t1_armed15");
    step(1'b1, 4'd0, 1'b0, 4'd0, ex(4'b0100, RUNNING, 8'd1), "t1_wrap");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
